// File: rtl/kv_response_builder.sv
// Joins lookup metadata with the matching RAM read value and frames a
// 512-bit AXI-Stream response (header beat, plus a value beat on a non-empty hit).
module kv_response_builder #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_meta_valid,
    input  logic [63:0]        s_axis_meta_key,
    input  logic               s_axis_meta_hit,
    output logic               s_axis_meta_ready,
    input  logic               s_axis_ram_valid,
    input  logic [15:0]        s_axis_ram_length,
    input  logic [511:0]       s_axis_ram_data,
    output logic               s_axis_ram_ready,
    output logic               m_axis_rsp_valid,
    output logic [511:0]       m_axis_rsp_data,
    output logic [63:0]        m_axis_rsp_keep,
    output logic               m_axis_rsp_last,
    input  logic               m_axis_rsp_ready,
    output logic [CNT_W-1:0]   stat_hit_count,
    output logic [CNT_W-1:0]   stat_miss_count,
    output logic [CNT_W-1:0]   stat_oversize_count
);
    localparam int unsigned DATA_W = 512;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned STAT_W = 8;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic [KEEP_W-1:0]   r_rsp_keep, w_rsp_keep_nxt;
    logic                r_rsp_last, w_rsp_last_nxt;
    logic [DATA_W-1:0]   r_val_data;
    logic [KEEP_W-1:0]   r_val_keep;
    logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt, r_ovs_cnt;

    logic                w_last_hs;
    logic                w_accept_ok;
    logic                w_capture;
    logic                w_oversize;
    logic [LEN_W-1:0]    w_eff_len;
    logic [STAT_W-1:0]   w_status;
    logic [KEEP_W-1:0]   w_val_keep;
    logic [DATA_W-1:0]   w_val_data;
    logic [DATA_W-1:0]   w_hdr;

    // A new pair may enter only when no response is pending past this cycle.
    assign w_last_hs         = r_rsp_valid && m_axis_rsp_ready && r_rsp_last;
    assign w_accept_ok       = !rst && ((r_state == IDLE) || w_last_hs);
    assign s_axis_meta_ready = w_accept_ok && s_axis_ram_valid;
    assign s_axis_ram_ready  = w_accept_ok && s_axis_meta_valid;
    assign w_capture         = w_accept_ok && s_axis_meta_valid && s_axis_ram_valid;

    assign w_oversize = s_axis_meta_hit && (s_axis_ram_length > LEN_W'(MAX_LEN));

    // Clamped length, status, byte enables and masked value for the incoming pair.
    always_comb begin
        w_eff_len  = '0;
        w_status   = '0;
        w_val_keep = '0;
        w_val_data = '0;
        w_hdr      = '0;
        if (s_axis_meta_hit) begin
            w_eff_len = w_oversize ? LEN_W'(MAX_LEN) : s_axis_ram_length;
            w_status  = w_oversize ? STAT_W'(2) : STAT_W'(1);
        end
        if (w_eff_len >= LEN_W'(KEEP_W)) begin
            w_val_keep = '1;
        end else begin
            w_val_keep = (KEEP_W'(1) << w_eff_len) - KEEP_W'(1);
        end
        for (int i = 0; i < KEEP_W; i++) begin
            w_val_data[i*8 +: 8] = w_val_keep[i] ? s_axis_ram_data[i*8 +: 8] : 8'h00;
        end
        w_hdr[63:0]  = s_axis_meta_key;
        w_hdr[79:64] = w_eff_len;
        w_hdr[87:80] = w_status;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_keep_nxt  = r_rsp_keep;
        w_rsp_last_nxt  = r_rsp_last;
        case (r_state)
            IDLE: ;
            HDR: begin
                if (r_rsp_valid && m_axis_rsp_ready && !r_rsp_last) begin
                    w_state_nxt    = DATA;
                    w_rsp_data_nxt = r_val_data;
                    w_rsp_keep_nxt = r_val_keep;
                    w_rsp_last_nxt = 1'b1;
                end
            end
            DATA: ;
            default: w_state_nxt = IDLE;
        endcase
        if (w_last_hs) begin
            w_state_nxt     = IDLE;
            w_rsp_valid_nxt = 1'b0;
        end
        // A capture overrides the return to IDLE so responses run back-to-back.
        if (w_capture) begin
            w_state_nxt     = HDR;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = w_hdr;
            w_rsp_keep_nxt  = KEEP_W'(11'h7FF);
            w_rsp_last_nxt  = (w_eff_len == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_keep  <= '0;
            r_rsp_last  <= 1'b0;
            r_val_data  <= '0;
            r_val_keep  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_keep  <= w_rsp_keep_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            if (w_capture) begin
                r_val_data <= w_val_data;
                r_val_keep <= w_val_keep;
            end
        end
    end

    // Saturating statistics, updated once per captured pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_ovs_cnt  <= '0;
        end else if (w_capture) begin
            if (s_axis_meta_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (!s_axis_meta_hit && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            if (w_oversize && (r_ovs_cnt != '1)) begin
                r_ovs_cnt <= r_ovs_cnt + CNT_W'(1);
            end
        end
    end

    assign m_axis_rsp_valid    = r_rsp_valid;
    assign m_axis_rsp_data     = r_rsp_data;
    assign m_axis_rsp_keep     = r_rsp_keep;
    assign m_axis_rsp_last     = r_rsp_last;
    assign stat_hit_count      = r_hit_cnt;
    assign stat_miss_count     = r_miss_cnt;
    assign stat_oversize_count = r_ovs_cnt;

endmodule

// File: tb/tb_kv_response_builder.sv
// Bench for kv_response_builder: directed and randomized pairs checked against
// a beat-queue reference model built from the response framing rules.
module tb_kv_response_builder;
    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         meta_valid, meta_hit, meta_ready;
    logic [63:0]  meta_key;
    logic         ram_valid, ram_ready;
    logic [15:0]  ram_length;
    logic [511:0] ram_data;
    logic         rsp_valid, rsp_last, rsp_ready;
    logic [511:0] rsp_data;
    logic [63:0]  rsp_keep;
    logic [31:0]  st_hit, st_miss, st_ovs;

    kv_response_builder #(.CNT_W(32), .MAX_LEN(64)) dut (
        .clk(clk), .rst(rst),
        .s_axis_meta_valid(meta_valid), .s_axis_meta_key(meta_key),
        .s_axis_meta_hit(meta_hit), .s_axis_meta_ready(meta_ready),
        .s_axis_ram_valid(ram_valid), .s_axis_ram_length(ram_length),
        .s_axis_ram_data(ram_data), .s_axis_ram_ready(ram_ready),
        .m_axis_rsp_valid(rsp_valid), .m_axis_rsp_data(rsp_data),
        .m_axis_rsp_keep(rsp_keep), .m_axis_rsp_last(rsp_last),
        .m_axis_rsp_ready(rsp_ready),
        .stat_hit_count(st_hit), .stat_miss_count(st_miss),
        .stat_oversize_count(st_ovs)
    );

    always #5 clk = ~clk;

    beat_t        exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         bp_en = 1'b0;
    logic         hold_pend = 1'b0;
    beat_t        hold_beat;
    int           beats_seen = 0;
    logic [31:0]  e_hit = 0, e_miss = 0, e_ovs = 0;

    task automatic chk(input logic [639:0] obs, input logic [639:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected beats straight from the framing rules.
    task automatic model(input logic [63:0] key, input logic hit, input int len, input logic [511:0] d);
        beat_t h, v;
        int    eff;
        eff = !hit ? 0 : (len > 64 ? 64 : len);
        h = '0;
        h.data[63:0]  = key;
        h.data[79:64] = 16'(eff);
        h.data[87:80] = !hit ? 8'h00 : (len > 64 ? 8'h02 : 8'h01);
        h.keep = 64'h7FF;
        h.last = (eff == 0);
        exp_q.push_back(h);
        if (eff > 0) begin
            v = '0;
            for (int i = 0; i < eff; i++) begin
                v.data[i*8 +: 8] = d[i*8 +: 8];
                v.keep[i] = 1'b1;
            end
            v.last = 1'b1;
            exp_q.push_back(v);
        end
        if (hit) e_hit++; else e_miss++;
        if (hit && len > 64) e_ovs++;
    endtask

    task automatic mon();
        beat_t cur, e;
        cur.data = rsp_data;
        cur.keep = rsp_keep;
        cur.last = rsp_last;
        if (hold_pend) begin
            chk(640'(rsp_valid), 640'(1), "hold_valid");
            chk(640'(cur), 640'(hold_beat), "hold_beat");
        end
        if (rsp_valid && rsp_ready) begin
            hold_pend = 1'b0;
            beats_seen++;
            if (exp_q.size() == 0) begin
                chk(640'(exp_q.size()), 640'(1), "extra_beat");
            end else begin
                e = exp_q.pop_front();
                chk(640'(cur.data), 640'(e.data), "beat_data");
                chk(640'(cur.keep), 640'(e.keep), "beat_keep");
                chk(640'(cur.last), 640'(e.last), "beat_last");
            end
        end else if (rsp_valid) begin
            hold_pend = 1'b1;
            hold_beat = cur;
        end else begin
            hold_pend = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        rsp_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Present one pair (meta may lead ram by 'lead' cycles); waits for the joint handshake.
    task automatic send(input logic [63:0] key, input logic hit, input int len,
                        input logic [511:0] d, input int lead, output int waited);
        logic done;
        meta_valid = 1'b1; meta_key = key; meta_hit = hit;
        ram_length = 16'(len); ram_data = d;
        ram_valid = (lead == 0);
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            chk(640'(meta_ready), 640'(0), "skew_meta_ready");
            mon();
            @(posedge clk);
            #1;
            rsp_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ram_valid = 1'b1;
        done = 1'b0;
        waited = 0;
        while (!done && waited < 300) begin
            @(negedge clk);
            mon();
            if (meta_ready || ram_ready) begin
                chk(640'({meta_ready, ram_ready}), 640'(2'b11), "join_both_ready");
                model(key, hit, len, d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            rsp_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!done) waited++;
        end
        if (!done) chk(640'(done), 640'(1), "send_timeout");
        meta_valid = 1'b0;
        ram_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
            tick();
            n++;
        end
        chk(640'(exp_q.size()), 640'(0), "drain_empty");
    endtask

    task automatic chk_stats(input string tag);
        chk(640'(st_hit), 640'(e_hit), {tag, "_hit_cnt"});
        chk(640'(st_miss), 640'(e_miss), {tag, "_miss_cnt"});
        chk(640'(st_ovs), 640'(e_ovs), {tag, "_ovs_cnt"});
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [511:0] inc;
        int           w;
        int           b0;
        for (int i = 0; i < 64; i++) inc[i*8 +: 8] = 8'(i);

        rst = 1'b1; rsp_ready = 1'b1;
        meta_valid = 1'b1; ram_valid = 1'b1; meta_key = '0; meta_hit = 1'b0;
        ram_length = '0; ram_data = '0;
        #1;
        chk(640'(rsp_valid), 640'(0), "rst_valid");
        chk(640'({rsp_data, rsp_keep, rsp_last}), 640'(0), "rst_beat");
        chk(640'({meta_ready, ram_ready}), 640'(0), "rst_readys");
        chk_stats("rst");
        meta_valid = 1'b0; ram_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        send(64'h1122334455667788, 1'b0, 32'h20, rand_data(), 0, w);
        drain();
        chk_stats("miss");

        send(64'hA5A5_0000_0000_0001, 1'b1, 20, inc, 0, w);
        drain();

        send(64'hDEAD_BEEF_0000_0002, 1'b1, 100, rand_data(), 0, w);
        drain();
        chk_stats("oversize");

        send(64'h0000_0000_0000_0003, 1'b1, 7, rand_data(), 5, w);
        send(64'h0000_0000_0000_0004, 1'b0, 0, rand_data(), 0, w);
        drain();

        // Back-to-back misses with the sink always ready: no waiting between captures.
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 1'b0, int'($urandom_range(0, 80)), rand_data(), 0, w);
            if (i > 0) chk(640'(w), 640'(0), "b2b_no_bubble");
        end
        drain();

        bp_en = 1'b1;
        b0 = beats_seen;
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, 1'b1, int'($urandom_range(1, 120)), rand_data(), 0, w);
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, 1'b0, int'($urandom_range(0, 120)), rand_data(), 0, w);
        drain();
        chk(640'(beats_seen - b0), 640'(12), "bp_beat_count");
        chk_stats("bp");

        for (int i = 0; i < 20; i++)
            send({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 100)),
                 rand_data(), int'($urandom_range(0, 2)), w);
        drain();
        chk_stats("mix");
        bp_en = 1'b0;

        // Reset while the value beat is stalled.
        send(64'h7777_0000_0000_0005, 1'b1, 20, inc, 0, w);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk(640'({rsp_valid, rsp_last}), 640'(2'b11), "pre_rst_data_beat");
        rst = 1'b1;
        meta_valid = 1'b1; ram_valid = 1'b1;
        #1;
        chk(640'(rsp_valid), 640'(0), "midrst_valid");
        chk(640'({meta_ready, ram_ready}), 640'(0), "midrst_readys");
        exp_q.delete();
        hold_pend = 1'b0;
        e_hit = 0; e_miss = 0; e_ovs = 0;
        chk_stats("midrst");
        meta_valid = 1'b0; ram_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 1'b1, 3, inc, 0, w);
        drain();
        chk_stats("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
